elevator_scheduler: RTL and testbench

- Sequences the 2-bit floor FSM:
  - latches hall/car calls for floors 0–3;
  - picks the next target with SCAN (keep direction while calls lie ahead, else reverse);
  - drives the FSM's requested-floor input and watches its current-floor output;
  - times door-open dwell at each stop.
- Sits between the call-button logic and the floor FSM.

---
 rtl/elev_pkg.sv | 21 ++
 rtl/elev_pick.sv | 46 ++++
 rtl/elevator_scheduler.sv | 172 +++++++++++++++++
 tb/tb_elevator_scheduler.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elev_pkg.sv
// Shared types and constants for the elevator scheduler.
package elev_pkg;

   localparam int unsigned NUM_FLOORS = 4;
   localparam int unsigned FLOOR_W    = 2;

   typedef logic [FLOOR_W-1:0]    floor_t;
   typedef logic [NUM_FLOORS-1:0] calls_t;

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      DOOR,
      FAULT
   } state_t;

   function automatic calls_t floor_mask(input floor_t f);
      return calls_t'(1) << f;
   endfunction

endpackage

// File: rtl/elev_pick.sv
// Nearest-pending-floor selector: reports calls ahead/behind the car and the
// nearest one, preferring the current direction of travel.
module elev_pick
   import elev_pkg::*;
(
   input  logic [NUM_FLOORS-1:0] pending,
   input  floor_t                cur_floor,
   input  logic                  dir_up,
   output logic                  found_ahead,
   output logic                  found_behind,
   output floor_t                target
);

   logic   up_found;
   logic   dn_found;
   floor_t up_t;
   floor_t dn_t;

   // Scan order makes the last hit the nearest one on each side.
   always_comb begin
      up_found = 1'b0;
      dn_found = 1'b0;
      up_t     = cur_floor;
      dn_t     = cur_floor;
      for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
         if (pending[i] && (FLOOR_W'(i) > cur_floor)) begin
            up_found = 1'b1;
            up_t     = FLOOR_W'(i);
         end
      end
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && (FLOOR_W'(i) < cur_floor)) begin
            dn_found = 1'b1;
            dn_t     = FLOOR_W'(i);
         end
      end
      found_ahead  = dir_up ? up_found : dn_found;
      found_behind = dir_up ? dn_found : up_found;
      if (found_ahead) begin
         target = dir_up ? up_t : dn_t;
      end else begin
         target = dir_up ? dn_t : up_t;
      end
   end

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN call scheduler driving the floor FSM, with door dwell timing.
// Optional move watchdog compiled in with ELEV_SCHED_WATCHDOG_EN.
module elevator_scheduler
   import elev_pkg::*;
#(
   parameter int unsigned DOOR_CYCLES  = 8,
   parameter int unsigned MOVE_TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] call_req,
   input  logic [FLOOR_W-1:0]    cur_floor,
   output logic [FLOOR_W-1:0]    floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  moving,
   output logic                  dir_up,
   output logic                  door_open,
   output logic                  fault
);

   localparam int unsigned CNT_W = (DOOR_CYCLES > 2) ? $clog2(DOOR_CYCLES) : 1;
   localparam logic [CNT_W-1:0] DOOR_LOAD = CNT_W'(DOOR_CYCLES - 1);

   if ((DOOR_CYCLES < 2) || (MOVE_TIMEOUT < 2) || (MOVE_TIMEOUT > 128)) begin : g_bad_params
      $error("elevator_scheduler: DOOR_CYCLES must be >=2, MOVE_TIMEOUT in 2..128");
   end

   state_t             state_q, state_d;
   calls_t             pending_q, pending_d;
   floor_t             floor_q, floor_d;
   logic               dir_up_q, dir_up_d;
   logic [CNT_W-1:0]   door_cnt_q, door_cnt_d;
   logic               moving_q, moving_d;
   logic               door_open_q, door_open_d;

   calls_t             call_lat;
   calls_t             pick_pend;
   logic               pick_ahead;
   logic               pick_behind;
   floor_t             pick_target;
   logic               retarget;

   // IDLE decides on already-latched calls; MOVE also sees this cycle's calls.
   assign call_lat  = pending_q | call_req;
   assign pick_pend = (state_q == MOVE) ? call_lat : pending_q;

   elev_pick u_pick (
      .pending      (pick_pend),
      .cur_floor    (cur_floor),
      .dir_up       (dir_up_q),
      .found_ahead  (pick_ahead),
      .found_behind (pick_behind),
      .target       (pick_target)
   );

   assign retarget = (state_q == MOVE) && (cur_floor != floor_q) && pick_ahead &&
                     (dir_up_q ? (pick_target < floor_q) : (pick_target > floor_q));

`ifdef ELEV_SCHED_WATCHDOG_EN
   localparam int unsigned MV_W = 7;
   logic [MV_W-1:0] mv_cnt_q, mv_cnt_d;
   logic            fault_q, fault_d;
`endif

   always_comb begin
      state_d    = state_q;
      pending_d  = call_lat;
      floor_d    = floor_q;
      dir_up_d   = dir_up_q;
      door_cnt_d = door_cnt_q;
`ifdef ELEV_SCHED_WATCHDOG_EN
      mv_cnt_d   = mv_cnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (pending_q[cur_floor]) begin
               state_d = DOOR;
            end else if (pick_ahead || pick_behind) begin
               dir_up_d = pick_ahead ? dir_up_q : ~dir_up_q;
               floor_d  = pick_target;
               state_d  = MOVE;
`ifdef ELEV_SCHED_WATCHDOG_EN
               mv_cnt_d = '0;
`endif
            end
         end
         MOVE: begin
            if (cur_floor == floor_q) begin
               state_d = DOOR;
            end else begin
               if (retarget) begin
                  floor_d = pick_target;
               end
`ifdef ELEV_SCHED_WATCHDOG_EN
               if (retarget) begin
                  mv_cnt_d = '0;
               end else if (mv_cnt_q == MV_W'(MOVE_TIMEOUT - 1)) begin
                  state_d = FAULT;
               end else begin
                  mv_cnt_d = mv_cnt_q + MV_W'(1);
               end
`endif
            end
         end
         DOOR: begin
            // A repeat call at the open floor holds the door instead of latching.
            pending_d = pending_q | (call_req & ~floor_mask(cur_floor));
            if (call_req[cur_floor]) begin
               door_cnt_d = DOOR_LOAD;
            end else if (door_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               door_cnt_d = door_cnt_q - CNT_W'(1);
            end
         end
         default: ;
      endcase

      if ((state_d == DOOR) && (state_q != DOOR)) begin
         pending_d  = pending_d & ~floor_mask(cur_floor);
         door_cnt_d = DOOR_LOAD;
      end

      moving_d    = (state_d == MOVE);
      door_open_d = (state_d == DOOR);
`ifdef ELEV_SCHED_WATCHDOG_EN
      fault_d     = (state_d == FAULT);
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         floor_q     <= '0;
         dir_up_q    <= 1'b1;
         door_cnt_q  <= '0;
         moving_q    <= 1'b0;
         door_open_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         floor_q     <= floor_d;
         dir_up_q    <= dir_up_d;
         door_cnt_q  <= door_cnt_d;
         moving_q    <= moving_d;
         door_open_q <= door_open_d;
      end
   end

`ifdef ELEV_SCHED_WATCHDOG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mv_cnt_q <= '0;
         fault_q  <= 1'b0;
      end else begin
         mv_cnt_q <= mv_cnt_d;
         fault_q  <= fault_d;
      end
   end
   assign fault = fault_q;
`else
   assign fault = 1'b0;
`endif

   assign floor     = floor_q;
   assign pending   = pending_q;
   assign moving    = moving_q;
   assign dir_up    = dir_up_q;
   assign door_open = door_open_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed vector tables, hand sequences and a
// randomized run against a behavioural SCAN model (watchdog part under ELEV_SCHED_WATCHDOG_EN).
module tb_elevator_scheduler;

   localparam int DOOR_CYCLES  = 8;
   localparam int MOVE_TIMEOUT = 64;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] call_req = '0;
   logic [1:0] cur_floor = '0;
   logic [1:0] floor;
   logic [3:0] pending;
   logic       moving, dir_up, door_open, fault;

   int checks = 0;
   int errors = 0;

   elevator_scheduler #(
      .DOOR_CYCLES  (DOOR_CYCLES),
      .MOVE_TIMEOUT (MOVE_TIMEOUT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .call_req  (call_req),
      .cur_floor (cur_floor),
      .floor     (floor),
      .pending   (pending),
      .moving    (moving),
      .dir_up    (dir_up),
      .door_open (door_open),
      .fault     (fault)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

   typedef struct {
      bit         rst;
      logic [3:0] call;
      logic [1:0] cur;
      logic [3:0] e_pend;
      logic [1:0] e_floor;
      bit         e_mov;
      bit         e_dir;
      bit         e_door;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(bit r, logic [3:0] c, logic [1:0] f, logic [3:0] p,
                               logic [1:0] fl, bit m, bit d, bit o);
      vec_t v;
      v.rst = r; v.call = c; v.cur = f; v.e_pend = p;
      v.e_floor = fl; v.e_mov = m; v.e_dir = d; v.e_door = o;
      return v;
   endfunction

   function automatic logic [9:0] dut_pack();
      return {fault, door_open, dir_up, moving, floor, pending};
   endfunction

   task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got {flt,door,dir,mov,floor,pend}=%b required %b", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      call_req = '0;
      cur_floor = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Behavioural model: mode 0 idle, 1 moving, 2 door, 3 fault; dir is +1/-1.
   int         m_mode, m_tgt, m_dir, m_dwell, m_mvclk;
   logic [3:0] m_pend;

   function automatic int nearest(input logic [3:0] p, input int cur, input int dir);
      int f;
      for (int d = 1; d < 4; d++) begin
         f = cur + dir * d;
         if (f >= 0 && f < 4) begin
            if (p[f]) return f;
         end
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_tgt = 0; m_dir = 1; m_dwell = 0; m_mvclk = 0; m_pend = '0;
   endtask

   task automatic model_step(input logic [3:0] c, input int cur);
      logic [3:0] np;
      bit         enter_door;
      int         t, n;
      np = m_pend | c;
      enter_door = 0;
      case (m_mode)
         0: begin
            if (m_pend[cur]) begin
               enter_door = 1;
            end else begin
               t = nearest(m_pend, cur, m_dir);
               if (t < 0) begin
                  t = nearest(m_pend, cur, -m_dir);
                  if (t >= 0) m_dir = -m_dir;
               end
               if (t >= 0) begin
                  m_tgt = t; m_mode = 1; m_mvclk = 0;
               end
            end
         end
         1: begin
            if (cur == m_tgt) begin
               enter_door = 1;
            end else begin
               n = nearest(np, cur, m_dir);
               if (n >= 0 && (n - cur) * m_dir < (m_tgt - cur) * m_dir) begin
                  m_tgt = n;
                  m_mvclk = 0;
               end else begin
`ifdef ELEV_SCHED_WATCHDOG_EN
                  m_mvclk++;
                  if (m_mvclk >= MOVE_TIMEOUT) m_mode = 3;
`endif
               end
            end
         end
         2: begin
            if (c[cur]) begin
               np[cur] = m_pend[cur];
               m_dwell = DOOR_CYCLES;
            end else if (m_dwell == 1) begin
               m_mode = 0;
            end else begin
               m_dwell--;
            end
         end
         default: ;
      endcase
      if (enter_door) begin
         np[cur] = 1'b0;
         m_mode = 2;
         m_dwell = DOOR_CYCLES;
      end
      m_pend = np;
   endtask

   function automatic logic [9:0] model_pack();
      return {m_mode == 3, m_mode == 2, m_dir > 0, m_mode == 1, 2'(m_tgt), m_pend};
   endfunction

   initial begin
      do_reset();
      chk("reset_state", dut_pack(), 10'b0010000000);

      // Trip 0->3 with a call at the arrival floor on the arrival edge.
      tbl.push_back(mk(1, 4'b1000, 2'd0, 4'b1000, 2'd0, 0, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd0, 4'b1000, 2'd3, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd1, 4'b1000, 2'd3, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd2, 4'b1000, 2'd3, 1, 1, 0));
      tbl.push_back(mk(0, 4'b1000, 2'd3, 4'b0000, 2'd3, 0, 1, 1));
      for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 4'b0000, 2'd3, 4'b0000, 2'd3, 0, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 2'd3, 4'b0000, 2'd3, 0, 1, 0));
      // Retarget to 2 during 0->3, serve 2, then continue to 3.
      tbl.push_back(mk(1, 4'b1000, 2'd0, 4'b1000, 2'd0, 0, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd0, 4'b1000, 2'd3, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0100, 2'd1, 4'b1100, 2'd2, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd2, 4'b1000, 2'd2, 0, 1, 1));
      for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 4'b0000, 2'd2, 4'b1000, 2'd2, 0, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 2'd2, 4'b1000, 2'd2, 0, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd2, 4'b1000, 2'd3, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd3, 4'b0000, 2'd3, 0, 1, 1));
      // Park at 2, call at 0 reverses direction; call at 3 waits until after 0.
      tbl.push_back(mk(1, 4'b0100, 2'd0, 4'b0100, 2'd0, 0, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd0, 4'b0100, 2'd2, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd1, 4'b0100, 2'd2, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd2, 4'b0000, 2'd2, 0, 1, 1));
      for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 4'b0000, 2'd2, 4'b0000, 2'd2, 0, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 2'd2, 4'b0000, 2'd2, 0, 1, 0));
      tbl.push_back(mk(0, 4'b0001, 2'd2, 4'b0001, 2'd2, 0, 1, 0));
      tbl.push_back(mk(0, 4'b1000, 2'd2, 4'b1001, 2'd0, 1, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd1, 4'b1001, 2'd0, 1, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd0, 4'b1000, 2'd0, 0, 0, 1));
      for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 4'b0000, 2'd0, 4'b1000, 2'd0, 0, 0, 1));
      tbl.push_back(mk(0, 4'b0000, 2'd0, 4'b1000, 2'd0, 0, 0, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd0, 4'b1000, 2'd3, 1, 1, 0));
      // Door at floor 1 reloaded with 3 clocks left.
      tbl.push_back(mk(1, 4'b0010, 2'd0, 4'b0010, 2'd0, 0, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd0, 4'b0010, 2'd1, 1, 1, 0));
      tbl.push_back(mk(0, 4'b0000, 2'd1, 4'b0000, 2'd1, 0, 1, 1));
      for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 4'b0000, 2'd1, 4'b0000, 2'd1, 0, 1, 1));
      tbl.push_back(mk(0, 4'b0010, 2'd1, 4'b0000, 2'd1, 0, 1, 1));
      for (int i = 0; i < 7; i++) tbl.push_back(mk(0, 4'b0000, 2'd1, 4'b0000, 2'd1, 0, 1, 1));
      tbl.push_back(mk(0, 4'b0000, 2'd1, 4'b0000, 2'd1, 0, 1, 0));

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         call_req  = tbl[i].call;
         cur_floor = tbl[i].cur;
         tick();
         chk($sformatf("vec%0d", i), dut_pack(),
             {1'b0, tbl[i].e_door, tbl[i].e_dir, tbl[i].e_mov, tbl[i].e_floor, tbl[i].e_pend});
         call_req = '0;
      end

      // Asynchronous reset while moving downward.
      do_reset();
      cur_floor = 2'd3;
      call_req = 4'b0001;
      tick();
      call_req = '0;
      tick();
      chk("pre_reset_move", dut_pack(), 10'b0001000001);
      cur_floor = 2'd2;
      call_req = 4'b1000;
      tick();
      call_req = '0;
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_reset", dut_pack(), 10'b0010000000);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("post_reset_idle", dut_pack(), 10'b0010000000);

`ifdef ELEV_SCHED_WATCHDOG_EN
      begin
         int n;
         do_reset();
         call_req = 4'b1000;
         tick();
         call_req = '0;
         tick();
         n = 1;
         while (moving && n < 200) begin
            tick();
            if (moving) n++;
         end
         chk("wd_move_clocks", 10'(n), 10'(MOVE_TIMEOUT));
         chk("wd_fault", dut_pack(), 10'b1010111000);
         repeat (5) tick();
         chk("wd_fault_sticky", dut_pack(), 10'b1010111000);
         do_reset();
         chk("wd_reset_clears", dut_pack(), 10'b0010000000);
      end
`endif

      // Randomized run; the floor FSM is emulated from the model's expectations.
      do_reset();
      model_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         call_req = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000;
         @(posedge clk);
         model_step(call_req, int'(cur_floor));
         #1;
         chk($sformatf("rand%0d", cyc), dut_pack(), model_pack());
         if (m_mode == 1 && int'(cur_floor) != m_tgt && $urandom_range(0, 2) != 0)
            cur_floor = 2'(int'(cur_floor) + m_dir);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
